n_zero_detect: RTL

N_ZERO_DETECT -- requirements
Module: n_zero_detect

---
 rtl/n_zero_detect_pkg.sv | 6 +
 rtl/n_zero_detect_ch.sv | 49 ++++
 rtl/n_zero_detect.sv | 43 ++++
 3 files changed

// File: rtl/n_zero_detect_pkg.sv
// n_zero_detect_pkg: mode encodings and event counter width shared by the detector
package n_zero_detect_pkg;
  localparam logic MODE_CUMULATIVE  = 1'b0;
  localparam logic MODE_CONSECUTIVE = 1'b1;
  localparam int   EVT_W            = 16;
endpackage

// File: rtl/n_zero_detect_ch.sv
// n_zero_detect_ch: one channel of the target-bit counter with Mealy pulse; N_ZERO_DETECT_EVENT_CNT_EN adds a pulse counter
module n_zero_detect_ch
  import n_zero_detect_pkg::*;
#(
  parameter int   COUNT_N = 3,
  parameter logic TARGET  = 1'b0,
  parameter int   CNT_W   = $clog2(COUNT_N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             in,
  input  logic             mode,
  input  logic             clear,
  output logic             out,
  output logic [CNT_W-1:0] count
`ifdef N_ZERO_DETECT_EVENT_CNT_EN
  ,
  output logic [EVT_W-1:0] event_cnt
`endif
);
  localparam logic [CNT_W:0]   LIMIT = (CNT_W+1)'(COUNT_N);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(COUNT_N - 1);
  logic [CNT_W-1:0] cur, nxt;
  logic             hit;
  // out-of-range counts behave as 0; Mealy pulse on the final target bit
  always_comb begin
    cur = ({1'b0, count} < LIMIT) ? count : '0;
    hit = en && (in == TARGET);
    out = !reset && !clear && hit && (cur == LAST);
    nxt = clear ? '0 :
          !en   ? count :
          hit   ? ((cur == LAST) ? '0 : cur + 1'b1) :
          (mode == MODE_CONSECUTIVE) ? '0 : cur;
  end
  // count register
  always_ff @(posedge clk or posedge reset)
    if (reset) count <= '0;
    else       count <= nxt;
`ifdef N_ZERO_DETECT_EVENT_CNT_EN
  logic [EVT_W-1:0] evt;
  // wrapping count of detection pulses
  always_ff @(posedge clk or posedge reset)
    if (reset)      evt <= '0;
    else if (clear) evt <= '0;
    else if (out)   evt <= evt + 1'b1;
  assign event_cnt = evt;
`endif
endmodule

// File: rtl/n_zero_detect.sv
// n_zero_detect: CHANNELS independent N-target-bit detectors; N_ZERO_DETECT_EVENT_CNT_EN adds per-channel pulse counters
module n_zero_detect
  import n_zero_detect_pkg::*;
#(
  parameter int   CHANNELS = 1,
  parameter int   COUNT_N  = 3,
  parameter logic TARGET   = 1'b0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS-1:0]       in,
  input  logic                      mode,
  input  logic                      clear,
  output logic [CHANNELS-1:0]       out,
  output logic [CHANNELS*$clog2(COUNT_N)-1:0] count
`ifdef N_ZERO_DETECT_EVENT_CNT_EN
  ,
  output logic [CHANNELS*EVT_W-1:0] event_cnt
`endif
);
  localparam int CNT_W = $clog2(COUNT_N);
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    n_zero_detect_ch #(
      .COUNT_N(COUNT_N),
      .TARGET (TARGET),
      .CNT_W  (CNT_W)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .en       (en[g]),
      .in       (in[g]),
      .mode     (mode),
      .clear    (clear),
      .out      (out[g]),
      .count    (count[g*CNT_W +: CNT_W])
`ifdef N_ZERO_DETECT_EVENT_CNT_EN
      ,
      .event_cnt(event_cnt[g*EVT_W +: EVT_W])
`endif
    );
  end
endmodule
